regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-port integer register file for the RISC-V core; replaces the fixed 32x32 2R1W file.
//  Adds configurable width/depth/read ports and a second write port (ALU + load writeback).
//  Adds write-to-read bypass, a hardwired-zero x0 and a per-register pending scoreboard for hazard detection.
//  Reset initialisation is a sequenced fill, one entry per cycle, gated by a ready flag.
// PARAMETERS
//  XLEN      32  data width in bits
//  NREGS     32  number of registers (power of 2, >=2); AW = $clog2(NREGS) is a localparam
//  NRD       2   number of read ports
//  INIT_MODE 1   0: fill every entry with 0; 1: entry i = i (zero-extended to XLEN)
//  ZERO_REG  1   1: entry 0 reads 0, ignores writes, never goes pending
// PORTS
//  clock      in   1         rising-edge clock
//  reset      in   1         synchronous, active-high reset
//  ready      out  1         0 during init fill, 1 once the file is usable
//  rd_addr    in   NRD*AW    packed read addresses; port k uses bits [k*AW +: AW]
//  rd_data    out  NRD*XLEN  packed read data (combinational)
//  rd_busy    out  NRD       per-port pending flag for rd_addr
//  wr0_en     in   1         write port 0 enable
//  wr0_addr   in   AW        write port 0 address
//  wr0_data   in   XLEN      write port 0 data
//  wr1_en     in   1         write port 1 enable; wins over port 0
//  wr1_addr   in   AW        write port 1 address
//  wr1_data   in   XLEN      write port 1 data
//  sb_set     in   1         mark sb_addr pending (instruction issued)
//  sb_addr    in   AW        register to mark pending
// BEHAVIOUR
//  FSM INIT/RUN. Reset (any cycle, including mid-fill) -> INIT, fill counter = 0, ready = 0, all pending bits = 0.
//  INIT: each cycle writes init value to entry[cnt], cnt++.
//   - After entry NREGS-1 is written, next state is RUN and ready = 1.
//   - Init takes exactly NREGS cycles after reset deasserts.
//  INIT: wr0/wr1/sb_set are ignored; rd_data = 0 and rd_busy = 0 on all ports.
//  RUN writes: array updates at posedge on enabled ports.
//   - Same address on both ports: wr1_data is stored.
//   - ZERO_REG=1: writes to address 0 are dropped.
//  RUN reads: zero-latency combinational, with bypass priority:
//   1. address 0 with ZERO_REG=1 -> 0
//   2. wr1 hits same address -> wr1_data
//   3. wr0 hits same address -> wr0_data
//   4. otherwise -> array contents
//  Scoreboard (RUN only), per-cycle update:
//   - An enabled write to addr a clears pending[a].
//   - sb_set sets pending[sb_addr].
//   - Set and clear on the same address in one cycle -> set wins, bit ends 1.
//   - ZERO_REG=1: pending[0] is held 0.
//  rd_busy[k] = pending[rd_addr_k] & ~(a write to rd_addr_k this cycle); consistent with the bypass.
//  No overflow/underflow conditions.
//   - Writing a register that is not pending is legal and leaves its bit 0.
//   - sb_set on an already-pending register is legal and keeps it 1.
//  Widths: addresses are unsigned AW bits; data is passed through unmodified, no sign handling.
// TESTING
//  1. reset 1 cycle, INIT_MODE=1:
//     - ready = 0 for exactly 32 cycles then 1.
//     - Read x10 -> 0x0000000A; x31 -> 0x0000001F.
//  2. Reset reasserted at fill cycle 5 -> counter restarts; ready rises 32 cycles after the second reset.
//  3. RUN, wr0 x5 = 0xDEADBEEF:
//     - Same-cycle read x5 -> 0xDEADBEEF (bypass).
//     - Next cycle reads 0xDEADBEEF from array.
//  4. wr0 x7 = 0x11 and wr1 x7 = 0x22 in the same cycle -> same-cycle read 0x22; stored 0x22.
//  5. Write x0 = 0xFFFFFFFF -> read x0 = 0. sb_set x0 -> rd_busy = 0.
//  6. sb_set x9:
//     - Next cycle rd_busy = 1.
//     - wr1 x9 = 0x5 -> rd_busy = 0 in that cycle, pending cleared.
//     - sb_set x9 together with wr0 x9 -> pending stays 1.

Source files
------------

// File: rtl/regfile_mp.sv
// Parametrised multi-port integer register file with write bypass, hardwired x0,
// pending-register scoreboard and a sequenced one-entry-per-cycle reset fill.
module regfile_mp #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int INIT_MODE = 1,
    parameter int ZERO_REG  = 1
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    output logic                         ready_o,
    input  logic [NRD*$clog2(NREGS)-1:0] rd_addr_i,
    output logic [NRD*XLEN-1:0]          rd_data_o,
    output logic [NRD-1:0]               rd_busy_o,
    input  logic                         wr0_en_i,
    input  logic [$clog2(NREGS)-1:0]     wr0_addr_i,
    input  logic [XLEN-1:0]              wr0_data_i,
    input  logic                         wr1_en_i,
    input  logic [$clog2(NREGS)-1:0]     wr1_addr_i,
    input  logic [XLEN-1:0]              wr1_data_i,
    input  logic                         sb_set_i,
    input  logic [$clog2(NREGS)-1:0]     sb_addr_i
);
    localparam int AW = $clog2(NREGS);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    logic [AW-1:0]       cnt_q;
    logic                ready_q;
    logic [XLEN-1:0]     mem_q [NREGS];
    logic [NREGS-1:0]    pending_q;
    logic [NREGS-1:0]    pending_d;
    logic                run_s;
    logic                wr0_ok_s;
    logic                wr1_ok_s;
    logic                sb_ok_s;
    logic [XLEN-1:0]     init_val_s;

    assign run_s      = (state_q == ST_RUN);
    assign ready_o    = ready_q;
    assign init_val_s = (INIT_MODE != 0) ? XLEN'(cnt_q) : {XLEN{1'b0}};

    // Qualified write/set strobes: inactive during fill, and x0 is immune when hardwired.
    always_comb begin
        wr0_ok_s = wr0_en_i & run_s;
        wr1_ok_s = wr1_en_i & run_s;
        sb_ok_s  = sb_set_i & run_s;
        if (ZERO_REG != 0) begin
            if (wr0_addr_i == {AW{1'b0}}) begin
                wr0_ok_s = 1'b0;
            end else begin
                wr0_ok_s = wr0_ok_s;
            end
            if (wr1_addr_i == {AW{1'b0}}) begin
                wr1_ok_s = 1'b0;
            end else begin
                wr1_ok_s = wr1_ok_s;
            end
            if (sb_addr_i == {AW{1'b0}}) begin
                sb_ok_s = 1'b0;
            end else begin
                sb_ok_s = sb_ok_s;
            end
        end else begin
            wr0_ok_s = wr0_ok_s;
            wr1_ok_s = wr1_ok_s;
            sb_ok_s  = sb_ok_s;
        end
    end

    // Scoreboard next state: writes clear, issue sets, and set is applied last so it wins.
    always_comb begin
        pending_d = pending_q;
        if (wr0_ok_s) begin
            pending_d[wr0_addr_i] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (wr1_ok_s) begin
            pending_d[wr1_addr_i] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
        if (sb_ok_s) begin
            pending_d[sb_addr_i] = 1'b1;
        end else begin
            pending_d = pending_d;
        end
        if (ZERO_REG != 0) begin
            pending_d[0] = 1'b0;
        end else begin
            pending_d = pending_d;
        end
    end

    // Read ports with bypass; everything reads as zero / not busy until the fill completes.
    always_comb begin
        rd_data_o = {(NRD*XLEN){1'b0}};
        rd_busy_o = {NRD{1'b0}};
        for (int k = 0; k < NRD; k++) begin
            logic [AW-1:0] a;
            logic          hit0;
            logic          hit1;
            a    = rd_addr_i[k*AW +: AW];
            hit0 = wr0_ok_s && (wr0_addr_i == a);
            hit1 = wr1_ok_s && (wr1_addr_i == a);
            if (!run_s) begin
                rd_data_o[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if ((ZERO_REG != 0) && (a == {AW{1'b0}})) begin
                rd_data_o[k*XLEN +: XLEN] = {XLEN{1'b0}};
            end else if (hit1) begin
                rd_data_o[k*XLEN +: XLEN] = wr1_data_i;
            end else if (hit0) begin
                rd_data_o[k*XLEN +: XLEN] = wr0_data_i;
            end else begin
                rd_data_o[k*XLEN +: XLEN] = mem_q[a];
            end
            rd_busy_o[k] = run_s & pending_q[a] & ~(hit0 | hit1);
        end
    end

    // INIT/RUN controller owning the fill counter, array, ready flag and scoreboard.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= ST_INIT;
            cnt_q     <= {AW{1'b0}};
            ready_q   <= 1'b0;
            pending_q <= {NREGS{1'b0}};
        end else begin
            case (state_q)
                ST_INIT: begin
                    mem_q[cnt_q] <= init_val_s;
                    cnt_q        <= cnt_q + {{(AW-1){1'b0}}, 1'b1};
                    pending_q    <= {NREGS{1'b0}};
                    if (cnt_q == AW'(NREGS - 1)) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wr0_ok_s) begin
                        mem_q[wr0_addr_i] <= wr0_data_i;
                    end
                    if (wr1_ok_s) begin
                        mem_q[wr1_addr_i] <= wr1_data_i;
                    end
                    pending_q <= pending_d;
                    ready_q   <= 1'b1;
                end
                default: begin
                    state_q   <= ST_INIT;
                    cnt_q     <= {AW{1'b0}};
                    ready_q   <= 1'b0;
                    pending_q <= {NREGS{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp: init fill, reset restart, bypass,
// write-port priority, hardwired x0 and the pending scoreboard.
module tb_regfile_mp;
    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int NRD = 2;
    localparam int AW = 5;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                ready_o;
    logic [NRD*AW-1:0]   rd_addr_i;
    logic [NRD*XLEN-1:0] rd_data_o;
    logic [NRD-1:0]      rd_busy_o;
    logic                wr0_en_i;
    logic [AW-1:0]       wr0_addr_i;
    logic [XLEN-1:0]     wr0_data_i;
    logic                wr1_en_i;
    logic [AW-1:0]       wr1_addr_i;
    logic [XLEN-1:0]     wr1_data_i;
    logic                sb_set_i;
    logic [AW-1:0]       sb_addr_i;

    int total_cnt = 0;
    int bad_cnt = 0;
    int n_cyc;

    regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .INIT_MODE(1), .ZERO_REG(1)) dut (
        .clock_i   (clk_i),
        .reset_i   (reset_i),
        .ready_o   (ready_o),
        .rd_addr_i (rd_addr_i),
        .rd_data_o (rd_data_o),
        .rd_busy_o (rd_busy_o),
        .wr0_en_i  (wr0_en_i),
        .wr0_addr_i(wr0_addr_i),
        .wr0_data_i(wr0_data_i),
        .wr1_en_i  (wr1_en_i),
        .wr1_addr_i(wr1_addr_i),
        .wr1_data_i(wr1_data_i),
        .sb_set_i  (sb_set_i),
        .sb_addr_i (sb_addr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        wr0_en_i = 1'b0; wr0_addr_i = 5'd0; wr0_data_i = 32'd0;
        wr1_en_i = 1'b0; wr1_addr_i = 5'd0; wr1_data_i = 32'd0;
        sb_set_i = 1'b0; sb_addr_i = 5'd0;
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr_i = {a1, a0};
    endtask

    // Starting at the first negedge after reset release, count cycles with ready low.
    task automatic wait_ready(output int n);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (ready_o === 1'b1) break;
            n++;
            @(negedge clk_i);
        end
    endtask

    task automatic pulse_reset();
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        idle();
        set_rd(5'd10, 5'd31);
        reset_i = 1'b1;
        @(negedge clk_i);
        pulse_reset();
        #1;
        check_val("reset_ready", {31'd0, ready_o}, 32'd0);
        check_val("init_rd_zero", rd_data_o[31:0], 32'd0);
        wait_ready(n_cyc);
        check_val("init_cycles", n_cyc, 32'd32);
        #1;
        check_val("x10_init", rd_data_o[31:0], 32'h0000000A);
        check_val("x31_init", rd_data_o[63:32], 32'h0000001F);

        // Reset again, then re-assert it after 5 fill cycles; writes during fill ignored.
        @(negedge clk_i);
        pulse_reset();
        set_rd(5'd3, 5'd3);
        wr0_en_i = 1'b1; wr0_addr_i = 5'd3; wr0_data_i = 32'h12345678;
        sb_set_i = 1'b1; sb_addr_i = 5'd3;
        #1;
        check_val("fill_rd_zero", rd_data_o[31:0], 32'd0);
        check_val("fill_busy_zero", {30'd0, rd_busy_o}, 32'd0);
        repeat (5) @(negedge clk_i);
        idle();
        pulse_reset();
        wait_ready(n_cyc);
        check_val("restart_cycles", n_cyc, 32'd32);
        #1;
        check_val("x3_after_fill", rd_data_o[31:0], 32'h00000003);
        check_val("x3_not_busy", {30'd0, rd_busy_o}, 32'd0);

        // Bypass of wr0, then array readback.
        @(negedge clk_i);
        set_rd(5'd5, 5'd6);
        wr0_en_i = 1'b1; wr0_addr_i = 5'd5; wr0_data_i = 32'hDEADBEEF;
        #1;
        check_val("x5_bypass", rd_data_o[31:0], 32'hDEADBEEF);
        check_val("x6_untouched", rd_data_o[63:32], 32'h00000006);
        @(negedge clk_i);
        idle();
        #1;
        check_val("x5_array", rd_data_o[31:0], 32'hDEADBEEF);

        // Both ports hit x7: wr1 wins in bypass and in storage.
        @(negedge clk_i);
        set_rd(5'd7, 5'd7);
        wr0_en_i = 1'b1; wr0_addr_i = 5'd7; wr0_data_i = 32'h11;
        wr1_en_i = 1'b1; wr1_addr_i = 5'd7; wr1_data_i = 32'h22;
        #1;
        check_val("x7_bypass_wr1", rd_data_o[63:32], 32'h22);
        @(negedge clk_i);
        idle();
        #1;
        check_val("x7_stored_wr1", rd_data_o[31:0], 32'h22);

        // x0 is hardwired zero and never pending.
        @(negedge clk_i);
        set_rd(5'd0, 5'd0);
        wr0_en_i = 1'b1; wr0_addr_i = 5'd0; wr0_data_i = 32'hFFFFFFFF;
        sb_set_i = 1'b1; sb_addr_i = 5'd0;
        #1;
        check_val("x0_bypass_zero", rd_data_o[31:0], 32'd0);
        @(negedge clk_i);
        idle();
        #1;
        check_val("x0_stored_zero", rd_data_o[31:0], 32'd0);
        check_val("x0_not_busy", {30'd0, rd_busy_o}, 32'd0);

        // Scoreboard on x9.
        @(negedge clk_i);
        set_rd(5'd9, 5'd8);
        sb_set_i = 1'b1; sb_addr_i = 5'd9;
        #1;
        check_val("x9_busy_before", {30'd0, rd_busy_o}, 32'd0);
        @(negedge clk_i);
        idle();
        #1;
        check_val("x9_busy_set", {30'd0, rd_busy_o}, 32'd1);
        @(negedge clk_i);
        #1;
        check_val("x9_busy_hold", {30'd0, rd_busy_o}, 32'd1);
        wr1_en_i = 1'b1; wr1_addr_i = 5'd9; wr1_data_i = 32'h5;
        #1;
        check_val("x9_busy_wr_cycle", {30'd0, rd_busy_o}, 32'd0);
        check_val("x9_wr1_bypass", rd_data_o[31:0], 32'h5);
        @(negedge clk_i);
        idle();
        #1;
        check_val("x9_cleared", {30'd0, rd_busy_o}, 32'd0);
        sb_set_i = 1'b1; sb_addr_i = 5'd9;
        wr0_en_i = 1'b1; wr0_addr_i = 5'd9; wr0_data_i = 32'h77;
        @(negedge clk_i);
        idle();
        #1;
        check_val("x9_set_wins", {30'd0, rd_busy_o}, 32'd1);
        check_val("x9_data_77", rd_data_o[31:0], 32'h77);
        check_val("x8_not_busy", {31'd0, rd_busy_o[1]}, 32'd0);

        // Reset clears pending.
        @(negedge clk_i);
        pulse_reset();
        wait_ready(n_cyc);
        check_val("reset3_cycles", n_cyc, 32'd32);
        #1;
        check_val("x9_pending_reset", {30'd0, rd_busy_o}, 32'd0);
        check_val("x9_refilled", rd_data_o[31:0], 32'h00000009);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
